// File: rtl/uart_console_ctrl.sv
// uart_console_ctrl: bus master for the iob_uart native register interface.
// It initialises the UART after reset and then shuttles bytes between the
// UART and a console: received bytes go into a small RX FIFO, and console
// bytes are written to TXDATA. RX and TX service alternate round-robin, and
// only one bus transaction is outstanding at any time.
// Optional feature macro: UART_CTRL_TIMEOUT_EN adds a bus watchdog. On a
// timeout it sets the sticky err flag and restarts the init sequence.
module uart_console_ctrl #(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 3,
    parameter logic [15:0]     DIV_VAL     = 16'd87,
    parameter int              RXF_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2),
    parameter logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3),
    parameter logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(4),
    parameter logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(5),
    parameter logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(6),
    parameter logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(7),
    parameter int              TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready,
    input  logic              tx_valid,
    input  logic [7:0]        tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              init_done,
    output logic              err
);

    localparam int PTR_W = $clog2(RXF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic RR_RX = 1'b0;
    localparam logic RR_TX = 1'b1;
    localparam logic [DATA_W-1:0] ONE_W  = DATA_W'(1);
    localparam logic [DATA_W-1:0] DIV_W  = DATA_W'(DIV_VAL);

    typedef enum logic [3:0] {
        I_SRST, I_SRSTC, I_DIV, I_TXEN, I_RXEN,
        IDLE, P_RX, R_RX, P_TX, W_TX
    } state_t;

    state_t            state_r, state_n;
    logic              valid_r, valid_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic [3:0]        wstrb_r, wstrb_n;
    logic              rr_r, rr_n;
    logic              init_done_r, init_done_n;
    logic [7:0]        tx_hold_r, tx_hold_n;

    logic [ADDR_W-1:0] req_addr_s;
    logic [DATA_W-1:0] req_wdata_s;
    logic [3:0]        req_wstrb_s;

    logic [7:0]        mem_r [RXF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s, pop_s, rx_elig_s, tx_elig_s;
    logic              timeout_s;
    logic              unused_rdata_s;

    assign unused_rdata_s = ^uart_rdata[DATA_W-1:8];

    assign rx_elig_s = (count_r != CNT_W'(RXF_DEPTH));
    assign tx_elig_s = tx_valid;
    assign pop_s     = rx_ready && (count_r != CNT_W'(0));

    assign uart_valid = valid_r;
    assign uart_addr  = addr_r;
    assign uart_wdata = wdata_r;
    assign uart_wstrb = wstrb_r;
    assign init_done  = init_done_r;
    assign rx_valid   = (count_r != CNT_W'(0));
    assign rx_data    = mem_r[rd_ptr_r];
    // The console sees the accept pulse in the same cycle the TXDATA write is acknowledged.
    assign tx_ready   = (state_r == W_TX) && valid_r && uart_ready;

`ifdef UART_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    logic [TO_W-1:0] to_cnt_r;
    logic            err_r;

    assign timeout_s = valid_r && !uart_ready && (to_cnt_r == TO_W'(TIMEOUT - 1));
    assign err       = err_r;

    // Watchdog: count cycles of an outstanding request, latch a sticky error on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= TO_W'(0);
            err_r    <= 1'b0;
        end else begin
            if (valid_r) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= TO_W'(0);
            end
            err_r <= err_r | timeout_s;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Request contents for the bus transaction that belongs to each state.
    always_comb begin
        req_addr_s  = A_SOFTRESET;
        req_wdata_s = '0;
        req_wstrb_s = 4'b0000;
        case (state_r)
            I_SRST:  begin req_addr_s = A_SOFTRESET; req_wdata_s = ONE_W; req_wstrb_s = 4'b0001; end
            I_SRSTC: begin req_addr_s = A_SOFTRESET; req_wdata_s = '0;    req_wstrb_s = 4'b0001; end
            I_DIV:   begin req_addr_s = A_DIV;       req_wdata_s = DIV_W; req_wstrb_s = 4'b0011; end
            I_TXEN:  begin req_addr_s = A_TXEN;      req_wdata_s = ONE_W; req_wstrb_s = 4'b0001; end
            I_RXEN:  begin req_addr_s = A_RXEN;      req_wdata_s = ONE_W; req_wstrb_s = 4'b0001; end
            P_RX:    begin req_addr_s = A_RXREADY; end
            R_RX:    begin req_addr_s = A_RXDATA; end
            P_TX:    begin req_addr_s = A_TXREADY; end
            W_TX:    begin req_addr_s = A_TXDATA; req_wdata_s = DATA_W'(tx_hold_r); req_wstrb_s = 4'b0001; end
            default: begin req_addr_s = A_SOFTRESET; end
        endcase
    end

    // Next-state logic: issue one request per bus state, advance on its acknowledge.
    always_comb begin
        state_n     = state_r;
        valid_n     = valid_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        wstrb_n     = wstrb_r;
        rr_n        = rr_r;
        init_done_n = init_done_r;
        tx_hold_n   = tx_hold_r;
        push_s      = 1'b0;
        if (timeout_s) begin
            valid_n     = 1'b0;
            init_done_n = 1'b0;
            state_n     = I_SRST;
        end else if (state_r == IDLE) begin
            if (rx_elig_s && ((rr_r == RR_RX) || !tx_elig_s)) begin
                state_n = P_RX;
            end else if (tx_elig_s) begin
                state_n   = P_TX;
                tx_hold_n = tx_data;
            end else begin
                state_n = IDLE;
            end
        end else if (!valid_r) begin
            // Entering a bus state always leaves valid low for one cycle first,
            // which guarantees the idle gap between transactions.
            valid_n = 1'b1;
            addr_n  = req_addr_s;
            wdata_n = req_wdata_s;
            wstrb_n = req_wstrb_s;
        end else if (uart_ready) begin
            valid_n = 1'b0;
            case (state_r)
                I_SRST:  state_n = I_SRSTC;
                I_SRSTC: state_n = I_DIV;
                I_DIV:   state_n = I_TXEN;
                I_TXEN:  state_n = I_RXEN;
                I_RXEN:  begin state_n = IDLE; init_done_n = 1'b1; end
                P_RX:    begin rr_n = RR_TX; state_n = uart_rdata[0] ? R_RX : IDLE; end
                R_RX:    begin push_s = 1'b1; state_n = IDLE; end
                P_TX:    begin rr_n = RR_RX; state_n = uart_rdata[0] ? W_TX : IDLE; end
                W_TX:    state_n = IDLE;
                default: state_n = I_SRST;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Controller state and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= I_SRST;
            valid_r     <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= 4'b0000;
            rr_r        <= RR_RX;
            init_done_r <= 1'b0;
            tx_hold_r   <= 8'h00;
        end else begin
            state_r     <= state_n;
            valid_r     <= valid_n;
            addr_r      <= addr_n;
            wdata_r     <= wdata_n;
            wstrb_r     <= wstrb_n;
            rr_r        <= rr_n;
            init_done_r <= init_done_n;
            tx_hold_r   <= tx_hold_n;
        end
    end

    // RX FIFO: push on RXDATA acknowledge, pop on console request; pointers wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RXF_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= uart_rdata[7:0];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_console_ctrl.sv
// Scoreboard bench for uart_console_ctrl. A UART register model acks each
// request two cycles after it appears. Expected bus transactions and RX bytes
// are queued when stimulus is set up and compared as the DUT produces them.
// Polls that return "not ready" are treated as background traffic.
module tb_uart_console_ctrl;

    logic        clk;
    logic        rst_n;
    logic        uart_valid;
    logic [2:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        init_done;
    logic        err;

    logic        rx_ready_t, rx_ready_b;
    assign rx_ready = rx_ready_t | rx_ready_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_bus [$];
    logic [7:0]  rx_src  [$];
    logic [7:0]  rx_exp  [$];
    logic [7:0]  tx_src  [$];
    logic        txready_v      = 1'b0;
    logic        nack_mode      = 1'b0;
    logic        pop_on_rxdata  = 1'b0;
    logic        drop_tx_on_poll = 1'b0;
    int          rx_polls  = 0;
    int          tx_pulses = 0;
    int          wait_cnt  = 0;

    uart_console_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .init_done  (init_done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transaction key; read data-phase value is irrelevant so it is masked.
    function automatic logic [31:0] mk(input logic [2:0] a, input logic [3:0] s, input logic [23:0] d);
        return {1'b0, a, s, (s == 4'b0000) ? 24'h0 : d};
    endfunction

    task automatic push_init();
        exp_bus.push_back(mk(3'd0, 4'b0001, 24'd1));
        exp_bus.push_back(mk(3'd0, 4'b0001, 24'd0));
        exp_bus.push_back(mk(3'd1, 4'b0011, 24'd87));
        exp_bus.push_back(mk(3'd3, 4'b0001, 24'd1));
        exp_bus.push_back(mk(3'd6, 4'b0001, 24'd1));
    endtask

    task automatic serve();
        logic [7:0]  rdv;
        logic        noise;
        logic [31:0] obs;
        logic [7:0]  hd;
        rdv   = 8'h00;
        noise = 1'b0;
        obs   = mk(uart_addr, uart_wstrb, uart_wdata[23:0]);
        case (uart_addr)
            3'd7: begin
                rx_polls++;
                noise = (rx_src.size() == 0);
                rdv   = {7'h0, !noise};
            end
            3'd4: begin
                noise = !txready_v;
                rdv   = {7'h0, txready_v};
                if (drop_tx_on_poll) begin
                    tx_src.delete();
                    drop_tx_on_poll = 1'b0;
                end
            end
            3'd5: begin
                if (rx_src.size() != 0) rdv = rx_src.pop_front();
                else rdv = 8'hEE;
                if (pop_on_rxdata) begin
                    pop_on_rxdata = 1'b0;
                    rx_ready_b = 1'b1;
                    check("pop_push_valid", {31'h0, rx_valid}, 32'h1);
                    if (rx_exp.size() != 0) begin
                        hd = rx_exp.pop_front();
                        check("pop_push_data", {24'h0, rx_data}, {24'h0, hd});
                    end else begin
                        check("pop_push_data", {24'h0, rx_data}, 32'hFFFF_FFFF);
                    end
                end
                rx_exp.push_back(rdv);
            end
            default: rdv = 8'h00;
        endcase
        if (!noise) begin
            if (exp_bus.size() == 0) check("bus_unexpected", obs, 32'hFFFF_FFFF);
            else check("bus_seq", obs, exp_bus.pop_front());
        end
        uart_rdata = {24'h0, rdv};
        uart_ready = 1'b1;
    endtask

    // UART register model: ack two cycles after valid, verify valid drops after ack.
    initial begin : bus_model
        uart_ready = 1'b0;
        uart_rdata = 32'h0;
        rx_ready_b = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_ready) begin
                uart_ready = 1'b0;
                rx_ready_b = 1'b0;
                check("valid_drop", {31'h0, uart_valid}, 32'h0);
                wait_cnt = 0;
            end else if (uart_valid && !nack_mode) begin
                wait_cnt++;
                if (wait_cnt == 2) serve();
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Console byte source: present queue head, retire it on each tx_ready pulse.
    initial begin : console
        logic [7:0] tmp;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (tx_ready) begin
                tx_pulses++;
                if (tx_src.size() != 0) tmp = tx_src.pop_front();
            end
            tx_valid = (tx_src.size() != 0);
            tx_data  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
        end
    end

    task automatic wait_exp(input string tag, input int limit);
        int n = 0;
        while (exp_bus.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, exp_bus.size(), 32'd0);
    endtask

    task automatic pop_rx(input string tag);
        int n = 0;
        logic [7:0] hd;
        while (!rx_valid && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, {31'h0, rx_valid}, 32'h1);
        if (rx_exp.size() != 0) begin
            hd = rx_exp.pop_front();
            check(tag, {24'h0, rx_data}, {24'h0, hd});
        end else begin
            check(tag, {24'h0, rx_data}, 32'hFFFF_FFFF);
        end
        rx_ready_t = 1'b1;
        @(negedge clk);
        #1;
        rx_ready_t = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n      = 1'b0;
        rx_ready_t = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", {31'h0, uart_valid}, 32'h0);
        check("rst_txr",   {31'h0, tx_ready},   32'h0);
        check("rst_rxv",   {31'h0, rx_valid},   32'h0);
        check("rst_rxd",   {24'h0, rx_data},    32'h0);
        check("rst_init",  {31'h0, init_done},  32'h0);
        check("rst_err",   {31'h0, err},        32'h0);

        // Init sequence
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_exp("init_seq", 200);
        check("init_done_pre", {31'h0, init_done}, 32'h0);
        @(negedge clk);
        #1;
        check("init_done", {31'h0, init_done}, 32'h1);

        // Single RX byte
        exp_bus.push_back(mk(3'd7, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd5, 4'b0000, 24'h0));
        rx_src.push_back(8'h41);
        wait_exp("rx_bus", 300);
        pop_rx("rx_41");
        check("rx_empty", {31'h0, rx_valid}, 32'h0);

        // Single TX byte
        tx_pulses = 0;
        txready_v = 1'b1;
        exp_bus.push_back(mk(3'd4, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd2, 4'b0001, 24'h5A));
        tx_src.push_back(8'h5A);
        wait_exp("tx_bus", 300);
        repeat (5) @(negedge clk);
        #1;
        check("tx_pulse1", tx_pulses, 32'd1);

        // TX byte whose tx_valid drops after the TXREADY poll
        drop_tx_on_poll = 1'b1;
        exp_bus.push_back(mk(3'd4, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd2, 4'b0001, 24'h33));
        tx_src.push_back(8'h33);
        wait_exp("tx_drop_bus", 300);
        repeat (5) @(negedge clk);
        #1;
        check("tx_pulse2", tx_pulses, 32'd2);
        check("tx_valid_low", {31'h0, tx_valid}, 32'h0);

        // Round-robin with both sides pending, from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tx_pulses = 0;
        push_init();
        for (int i = 0; i < 4; i++) begin
            exp_bus.push_back(mk(3'd7, 4'b0000, 24'h0));
            exp_bus.push_back(mk(3'd5, 4'b0000, 24'h0));
            exp_bus.push_back(mk(3'd4, 4'b0000, 24'h0));
            exp_bus.push_back(mk(3'd2, 4'b0001, 24'hA0 + 24'(i)));
            tx_src.push_back(8'hA0 + 8'(i));
        end
        for (int i = 0; i < 6; i++) rx_src.push_back(8'h10 + 8'(i));
        rst_n = 1'b1;
        wait_exp("rr_bus", 800);
        repeat (10) @(negedge clk);
        rx_polls = 0;
        repeat (60) @(negedge clk);
        #1;
        check("full_no_poll", rx_polls, 32'd0);
        check("rr_tx_pulses", tx_pulses, 32'd4);
        check("full_rxv", {31'h0, rx_valid}, 32'h1);

        // Same-cycle push and pop with pointer wrap
        exp_bus.push_back(mk(3'd7, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd5, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd7, 4'b0000, 24'h0));
        exp_bus.push_back(mk(3'd5, 4'b0000, 24'h0));
        rx_src.push_back(8'h16);
        pop_on_rxdata = 1'b1;
        pop_rx("pop_10");
        wait_exp("refill_bus", 400);
        repeat (10) @(negedge clk);
        rx_polls = 0;
        repeat (60) @(negedge clk);
        #1;
        check("refull_no_poll", rx_polls, 32'd0);
        rx_src.delete();
        for (int i = 0; i < 4; i++) pop_rx("drain");
        check("drain_empty", {31'h0, rx_valid}, 32'h0);
        check("drain_sb", rx_exp.size(), 32'd0);

`ifdef UART_CTRL_TIMEOUT_EN
        // Watchdog: first write never acknowledged
        begin
            int n = 0;
            int w = 0;
            @(negedge clk);
            rst_n = 1'b0;
            nack_mode = 1'b1;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            while (!uart_valid && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            while (uart_valid && n < 3000) begin
                n++;
                @(negedge clk);
                #1;
            end
            check("to_cycles", n, 32'd1024);
            check("to_err", {31'h0, err}, 32'h1);
            check("to_init", {31'h0, init_done}, 32'h0);
            nack_mode = 1'b0;
            push_init();
            wait_exp("to_reinit", 300);
            repeat (3) @(negedge clk);
            #1;
            check("to_init_done", {31'h0, init_done}, 32'h1);
            check("to_err_sticky", {31'h0, err}, 32'h1);
        end
`else
        check("err_low", {31'h0, err}, 32'h0);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
